// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES encryption engine.
//   AES_BLOCK_W : width of one AES state / round key (128 bits)
//   ROUND_W     : width of the round counter (4 bits, so Nr may be at most 15)
//   KEY_SLOTS   : number of round keys addressable by a 4-bit counter
//   fsm_e       : controller state encoding (IDLE, ROUND, DONE)
//   sbox()      : forward AES S-box lookup (SubBytes on one byte)
//   key_at()    : slice round key r out of a packed key schedule
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int ROUND_W     = 4;
    localparam int ROUND_MAX   = (1 << ROUND_W) - 1;
    localparam int KEY_SLOTS   = ROUND_MAX + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_e;

    // Forward S-box, entry 0 in the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // The schedule is always presented KEY_SLOTS wide; unused upper slots read as zero.
    function automatic logic [AES_BLOCK_W-1:0] key_at(
        input logic [KEY_SLOTS*AES_BLOCK_W-1:0] keys,
        input logic [ROUND_W-1:0]               r
    );
        return keys[AES_BLOCK_W*int'(r) +: AES_BLOCK_W];
    endfunction

endpackage

// File: rtl/aes_encrypt_engine_ctrl_if.sv
// -----------------------------------------------------------------------------
// aes_encrypt_engine_ctrl_if
// Block-stream interface of the AES engine: ready/valid plaintext input and
// ready/valid ciphertext output.
//   in_valid / in_ready / in_data    : plaintext offer (byte 0 in [127:120])
//   out_valid / out_ready / out_data : ciphertext presentation
//   master : block producer / ciphertext consumer (system side)
//   slave  : the engine
// -----------------------------------------------------------------------------
interface aes_encrypt_engine_ctrl_if;

    logic                              in_valid;
    logic                              in_ready;
    logic [aes_pkg::AES_BLOCK_W-1:0]   in_data;
    logic                              out_valid;
    logic                              out_ready;
    logic [aes_pkg::AES_BLOCK_W-1:0]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/aes_round.sv
// -----------------------------------------------------------------------------
// aes_round
// One combinational AES encryption round:
//   state_out = AddRoundKey(MixColumns(ShiftRows(SubBytes(state_in))), round_key)
// with MixColumns bypassed when final_flag is set.
//   state_in   : current state, byte 0 in [127:120], column-major byte order
//   round_key  : round key applied at the end of this round
//   final_flag : last round, skip MixColumns
//   state_out  : next state
// -----------------------------------------------------------------------------
module aes_round
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state_in,
    input  logic [AES_BLOCK_W-1:0] round_key,
    input  logic                   final_flag,
    output logic [AES_BLOCK_W-1:0] state_out
);

    logic [7:0]             sb_b [16];
    logic [7:0]             sr_b [16];
    logic [7:0]             mc_b [16];
    logic [AES_BLOCK_W-1:0] pre_key;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb_b[i] = sbox(state_in[AES_BLOCK_W-1-8*i -: 8]);
        end
    end

    // ShiftRows: byte index is row + 4*column; row r rotates left by r columns.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_b[4*c+r] = sb_b[4*((c+r)%4)+r];
            end
        end
    end

    // MixColumns: each column times the circulant {02,03,01,01}.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc_b[4*c+0] = xtime(sr_b[4*c+0]) ^ xtime(sr_b[4*c+1]) ^ sr_b[4*c+1]
                        ^ sr_b[4*c+2] ^ sr_b[4*c+3];
            mc_b[4*c+1] = sr_b[4*c+0] ^ xtime(sr_b[4*c+1]) ^ xtime(sr_b[4*c+2])
                        ^ sr_b[4*c+2] ^ sr_b[4*c+3];
            mc_b[4*c+2] = sr_b[4*c+0] ^ sr_b[4*c+1] ^ xtime(sr_b[4*c+2])
                        ^ xtime(sr_b[4*c+3]) ^ sr_b[4*c+3];
            mc_b[4*c+3] = xtime(sr_b[4*c+0]) ^ sr_b[4*c+0] ^ sr_b[4*c+1]
                        ^ sr_b[4*c+2] ^ xtime(sr_b[4*c+3]);
        end
    end

    // AddRoundKey
    always_comb begin
        pre_key = '0;
        for (int i = 0; i < 16; i++) begin
            pre_key[AES_BLOCK_W-1-8*i -: 8] = final_flag ? sr_b[i] : mc_b[i];
        end
        state_out = pre_key ^ round_key;
    end

endmodule

// File: rtl/aes_encrypt_engine_ctrl.sv
// -----------------------------------------------------------------------------
// aes_encrypt_engine_ctrl
// Iterative AES encryption engine. Accepts one plaintext block, applies the
// initial key XOR on the accept edge, then runs one aes_round per clock for
// rounds 1..Nr (MixColumns skipped in round Nr) and holds the ciphertext until
// the consumer takes it. A new block may be accepted on the same edge the
// previous ciphertext is consumed.
//   clk, rst  : clock, synchronous active-high reset
//   blk       : slave side of the block-stream interface
//   all_keys  : full key schedule, round key r at [128*r +: 128]; not latched,
//               must be stable from the accept edge through the final round
//   busy      : high while rounds are in progress
// Parameters: Nk (key words, informational), Nr (rounds, 1..15).
// -----------------------------------------------------------------------------
module aes_encrypt_engine_ctrl
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
)
(
    input  logic                           clk,
    input  logic                           rst,
    aes_encrypt_engine_ctrl_if.slave       blk,
    input  logic [(Nr+1)*AES_BLOCK_W-1:0]  all_keys,
    output logic                           busy
);

    localparam int  KEYS_W = (Nr + 1) * AES_BLOCK_W;
    localparam bit  CFG_OK = (Nr >= 1) && (Nr <= ROUND_MAX) && (Nk >= 4) && (Nk <= 8);

    if (!CFG_OK) begin : g_cfg_check
        $error("aes_encrypt_engine_ctrl: Nr must be 1..15 and Nk 4..8");
    end

    fsm_e                             fsm_q;
    logic [ROUND_W-1:0]               round_q;
    logic [AES_BLOCK_W-1:0]           state_q;
    logic                             idle_q;
    logic                             out_valid_q;
    logic                             busy_q;

    logic [KEY_SLOTS*AES_BLOCK_W-1:0] keys_ext;
    logic [AES_BLOCK_W-1:0]           key0;
    logic [AES_BLOCK_W-1:0]           round_key;
    logic [AES_BLOCK_W-1:0]           round_out;
    logic                             final_round;
    logic                             accept;

    always_comb begin
        keys_ext               = '0;
        keys_ext[KEYS_W-1:0]   = all_keys;
    end

    assign key0        = key_at(keys_ext, ROUND_W'(0));
    assign round_key   = key_at(keys_ext, round_q);
    assign final_round = (round_q == ROUND_W'(Nr));

    // in_ready looks through to out_ready in DONE so a consumed block can be
    // replaced on the same edge without a bubble.
    assign blk.in_ready  = idle_q | (out_valid_q & blk.out_ready);
    assign accept        = blk.in_valid & blk.in_ready;
    assign blk.out_valid = out_valid_q;
    assign blk.out_data  = state_q;
    assign busy          = busy_q;

    aes_round u_round (
        .state_in   (state_q),
        .round_key  (round_key),
        .final_flag (final_round),
        .state_out  (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            round_q     <= '0;
            state_q     <= '0;
            idle_q      <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= blk.in_data ^ key0;
                        round_q <= ROUND_W'(1);
                        fsm_q   <= ROUND;
                        idle_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                ROUND: begin
                    state_q <= round_out;
                    if (final_round) begin
                        round_q     <= '0;
                        fsm_q       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        round_q <= round_q + ROUND_W'(1);
                    end
                end

                DONE: begin
                    if (blk.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (blk.in_valid) begin
                            // Pop and push on one edge.
                            state_q <= blk.in_data ^ key0;
                            round_q <= ROUND_W'(1);
                            fsm_q   <= ROUND;
                            busy_q  <= 1'b1;
                        end else begin
                            // Ciphertext stays visible on out_data after the pop.
                            fsm_q  <= IDLE;
                            idle_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    fsm_q       <= IDLE;
                    round_q     <= '0;
                    idle_q      <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_engine_ctrl.sv
module tb_aes_encrypt_engine_ctrl;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam int           LAT    = 11;
    localparam int           NVEC   = 8;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           hold;
    } vec_t;

    logic               clk;
    logic               rst;
    logic [11*128-1:0]  all_keys;
    logic               busy;
    int                 n_checks;
    int                 n_errors;
    vec_t               vecs [NVEC];

    aes_encrypt_engine_ctrl_if bus ();

    aes_encrypt_engine_ctrl #(.Nk(4), .Nr(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .blk      (bus.slave),
        .all_keys (all_keys),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model (byte-matrix AES from GF(2^8) math) ----
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, then the FIPS-197 affine transform.
    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] x, p, s;
        x = a; p = 8'h01;
        for (int k = 1; k < 8; k++) begin
            x = gmul(x, x);
            p = gmul(p, x);
        end
        s = p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [11*128-1:0] expand(input logic [127:0] key);
        logic [31:0]       w [44];
        logic [31:0]       t;
        logic [7:0]        rc;
        logic [11*128-1:0] ks;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [11*128-1:0] ks;
        logic [7:0]        s [4][4];
        logic [7:0]        t [4][4];
        logic [7:0]        coef [4];
        logic [7:0]        acc;
        logic [127:0]      v;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        ks = expand(key);
        v  = pt ^ ks[127:0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r][c] = sb(v[127-8*(4*c+r) -: 8]);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = s[r][(c+r)%4];
            if (rnd < 10) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k-r+4)%4], t[k][c]);
                        s[r][c] = acc;
                    end
            end else begin
                s = t;
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) v[127-8*(4*c+r) -: 8] = s[r][c];
            v = v ^ ks[128*rnd +: 128];
        end
        return v;
    endfunction

    // ---------------- checking helpers ---------------------------------------
    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        check(nm, {127'b0, act}, {127'b0, exp});
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        check(nm, 128'(act), 128'(exp));
    endtask

    task automatic drive_garbage();
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Single block with backpressure of v.hold cycles; in_valid noise while busy.
    task automatic encrypt_one(input vec_t v, input string nm);
        int n;
        @(negedge clk);
        all_keys      = expand(v.key);
        bus.in_valid  = 1'b1;
        bus.in_data   = v.pt;
        bus.out_ready = 1'b0;
        #1 check_bit({nm, ".ready_idle"}, bus.in_ready, 1'b1);
        @(negedge clk);
        n = 1;
        check_bit({nm, ".busy"}, busy, 1'b1);
        check_bit({nm, ".ready_round"}, bus.in_ready, 1'b0);
        drive_garbage();
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
            drive_garbage();
        end
        check_int({nm, ".latency"}, n, LAT);
        check({nm, ".ct"}, bus.out_data, v.ct);
        repeat (v.hold) begin
            @(negedge clk);
            drive_garbage();
            check_bit({nm, ".hold_valid"}, bus.out_valid, 1'b1);
            check({nm, ".hold_data"}, bus.out_data, v.ct);
            check_bit({nm, ".hold_ready"}, bus.in_ready, 1'b0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1 check_bit({nm, ".ready_pop"}, bus.in_ready, 1'b1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        check_bit({nm, ".valid_after_pop"}, bus.out_valid, 1'b0);
        check_bit({nm, ".idle_ready"}, bus.in_ready, 1'b1);
        check_bit({nm, ".idle_busy"}, busy, 1'b0);
        check({nm, ".data_kept"}, bus.out_data, v.ct);
    endtask

    task automatic back_to_back();
        int n;
        @(negedge clk);
        all_keys      = expand(C1_KEY);
        bus.in_valid  = 1'b1;
        bus.in_data   = C1_PT;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_data = B_PT;
        n = 1;
        check_bit("b2b.busy1", busy, 1'b1);
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_int("b2b.latency1", n, LAT);
        check("b2b.ct1", bus.out_data, C1_CT);
        all_keys = expand(B_KEY);
        #1 check_bit("b2b.ready_swap", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        check_bit("b2b.busy2", busy, 1'b1);
        check_bit("b2b.valid_gap", bus.out_valid, 1'b0);
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_int("b2b.spacing", n, LAT);
        check("b2b.ct2", bus.out_data, B_CT);
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        check_bit("b2b.valid_end", bus.out_valid, 1'b0);
        check_bit("b2b.ready_end", bus.in_ready, 1'b1);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        all_keys      = expand(C1_KEY);
        bus.in_valid  = 1'b1;
        bus.in_data   = C1_PT;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_bit("rstmid.busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_bit("rstmid.valid", bus.out_valid, 1'b0);
        check_bit("rstmid.busy_after", busy, 1'b0);
        check_bit("rstmid.ready", bus.in_ready, 1'b1);
        check("rstmid.data", bus.out_data, 128'h0);
    endtask

    // ---------------- main sequence -------------------------------------------
    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        all_keys      = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("reset.in_ready", bus.in_ready, 1'b1);
        check_bit("reset.out_valid", bus.out_valid, 1'b0);
        check_bit("reset.busy", busy, 1'b0);
        check("reset.out_data", bus.out_data, 128'h0);
        rst = 1'b0;

        vecs[0] = '{key: C1_KEY, pt: C1_PT, ct: C1_CT, hold: 0};
        vecs[1] = '{key: B_KEY,  pt: B_PT,  ct: B_CT,  hold: 20};
        for (int i = 2; i < NVEC; i++) begin
            vecs[i].key  = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].pt   = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].ct   = model_encrypt(vecs[i].key, vecs[i].pt);
            vecs[i].hold = int'($urandom_range(0, 3));
        end

        for (int i = 0; i < NVEC; i++) encrypt_one(vecs[i], $sformatf("vec%0d", i));

        back_to_back();
        reset_mid();
        encrypt_one(vecs[0], "after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
